sync_fifo_ctrl: RTL and testbench
=================================

# sync_fifo_ctrl

Single-clock FIFO controller that sequences `dual_port_ram` as a first-in-first-out buffer. It accepts push/pop requests from a producer and a consumer, and drives the RAM write port (`wr_addr`, `wr_en`, `wr_data`) and read port (`rd_addr`). It tracks occupancy with modulo-`FIFO_DEPTH` pointers, which also handle non-power-of-two depths such as 90, and reports `full`, `empty`, `almost_full`, `count` and a read-valid strobe. In the FIFO subsystem it sits between the requesters and the RAM instance; both RAM clocks tie to `clk`.

## Interface
- `DATA_WIDTH`, 8, data word width; must match the RAM.
- `FIFO_DEPTH`, 90, number of words; any value ≥ 2.
- `PTR_WIDTH`, `$clog2(FIFO_DEPTH)+1`, RAM address and `count` width.
- `AF_LEVEL`, `FIFO_DEPTH-4`, `almost_full` threshold; legal range 1..`FIFO_DEPTH`.
- `clk`  in  1  single clock; also drives RAM `wr_clk` and `rd_clk`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `push`  in  1  write request.
- `push_data`  in  `DATA_WIDTH`  word to write.
- `pop`  in  1  read request.
- `flush`  in  1  synchronous clear of pointers and count.
- `err_clr`  in  1  clears sticky error flags (only with `FIFO_ERR_FLAGS_EN`).
- `ram_wr_en`  out  1  to RAM `wr_en`.
- `ram_wr_addr`  out  `PTR_WIDTH`  to RAM `wr_addr`.
- `ram_wr_data`  out  `DATA_WIDTH`  to RAM `wr_data`.
- `ram_rd_addr`  out  `PTR_WIDTH`  to RAM `rd_addr`.
- `rd_valid`  out  1  RAM `rd_data` holds the popped word this cycle.
- `full`, `empty`, `almost_full`  out  1 each  status flags.
- `count`  out  `PTR_WIDTH`  occupancy, 0..`FIFO_DEPTH`.
- `overflow`, `underflow`  out  1 each  sticky error flags.

## Operation
- Internal registers:
  - `wptr` and `rptr`, range 0..`FIFO_DEPTH-1`, zero-extended to `PTR_WIDTH` on the RAM address ports.
  - `cnt`, the registered occupancy.
- Push acceptance: `push_ok = push & ~full`.
  - `full` means `cnt == FIFO_DEPTH`.
  - A push with `full` high is dropped, even if a pop is accepted in the same cycle.
- Pop acceptance: `pop_ok = pop & ~empty`.
  - `empty` means `cnt == 0`.
  - A pop with `empty` high is dropped, even if a push is accepted in the same cycle.
- RAM write port (combinational): `ram_wr_en = push_ok`, `ram_wr_addr = wptr`, `ram_wr_data = push_data`.
- RAM read port: `ram_rd_addr = rptr` (combinational).
- Pointer update: on `push_ok`, `wptr` advances; on `pop_ok`, `rptr` advances. Increment wraps `FIFO_DEPTH-1` → 0. No power-of-two masking.
- Occupancy update: `cnt` +1 on `push_ok` only, −1 on `pop_ok` only, unchanged when both or neither.
- `almost_full = (cnt >= AF_LEVEL)`.
- All flags are decoded from registered `cnt`, so they are glitch-free and update the cycle after the causing edge.
- `flush`:
  - Takes priority over push and pop in the same cycle; neither is accepted.
  - Next state: pointers = 0, `cnt` = 0, `rd_valid` = 0.
  - Does not clear error flags.
- Reset values (asynchronous): `wptr`, `rptr`, `cnt`, `rd_valid`, `overflow`, `underflow` = 0. Hence `empty`=1, `full`=0, `almost_full`=0, `count`=0.
- Reset mid-operation discards the contents. A pending `rd_valid` is killed immediately.

## Timing
- Write: accepted on edge N; the word is in RAM after edge N.
- Read latency is 1 cycle:
  - `pop_ok` in cycle N → RAM captures `mem[rptr]` at edge N and `rptr` advances.
  - `rd_valid` = 1 during cycle N+1, with the word on RAM `rd_data`.
- Back-to-back pops give one word per cycle.
- Write-to-read: a word pushed at edge N into an empty FIFO can be popped in cycle N+1 (`empty` falls after edge N). `rd_valid` then asserts in cycle N+2 with the correct data. No same-address collision can occur, since pop is blocked while empty.
- Simultaneous push and pop at 0 < `cnt` < `FIFO_DEPTH`: both are accepted and `count` is unchanged.

## Configuration
- Macro: `FIFO_ERR_FLAGS_EN`.
- Defined:
  - `overflow` sets on `push & full`; `underflow` sets on `pop & empty`.
  - Both are sticky until `err_clr`. When `err_clr` coincides with a new error, the set wins.
- Undefined: `overflow` and `underflow` are tied to 0, `err_clr` is ignored, and no flag registers are inferred.

## Structure
- `fifo_pkg` holds:
  - the `ptr_w(depth)` function (`$clog2(depth)+1`);
  - default `DATA_WIDTH` and `FIFO_DEPTH` constants.
- Sub-module `fifo_wrap_ptr`: a modulo-`FIFO_DEPTH` pointer register with `inc`, `clr` and async `rst_n`. It is instantiated twice, for `wptr` and `rptr`.
- The RAM is instantiated by the parent FIFO wrapper, not inside this block.

## Test plan
- Reset, then idle → `empty`=1, `count`=0, `rd_valid`=0. Push 0xA5 → next cycle `count`=1, `empty`=0. Pop → `rd_valid` one cycle later with `rd_data`=0xA5.
- Fill, `FIFO_DEPTH`=90: push 0..89 → `almost_full` rises at `count`=86, `full` at 90. A 91st push is dropped and `overflow`=1 (macro on).
- Wrap-around: push 90 words, pop 45, push 45 more (`wptr` wraps 89 → 0) → pop all 90 and check order; `ram_rd_addr` goes 89 → 0.
- Simultaneous push and pop:
  - at `count`=10, held for 20 cycles → `count` stays 10 and data stays in order;
  - at `full` → pop accepted, push dropped, `count`=89;
  - at `empty` → push accepted, pop dropped, `count`=1, no `rd_valid`.
- `flush` with push and pop at `count`=50 → next cycle `count`=0, `empty`=1, no write (`ram_wr_en`=0).
- Assert `rst_n` low mid-stream while `rd_valid` is 1 → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
// Provides default geometry and the pointer/count width function.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 90;

    // Address/count width: one extra bit so count can hold FIFO_DEPTH
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer register (wraps DEPTH-1 -> 0, any DEPTH >= 2).
// Ports: clk, rst_n (async low), clr (sync), inc, ptr (W bits).
module fifo_wrap_ptr #(
    parameter int DEPTH = 90,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving an external dual-port RAM.
// Inputs: clk, rst_n, push, push_data, pop, flush, err_clr.
// Outputs: ram_wr_en/addr/data, ram_rd_addr, rd_valid, full, empty,
// almost_full, count, overflow, underflow.
// Optional: FIFO_ERR_FLAGS_EN enables sticky overflow/underflow flags.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int PTR_WIDTH  = ptr_w(FIFO_DEPTH),
    parameter int AF_LEVEL   = FIFO_DEPTH - 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic                  ram_wr_en,
    output logic [PTR_WIDTH-1:0]  ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [PTR_WIDTH-1:0]  ram_rd_addr,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [PTR_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH-1:0] DEPTH_C = PTR_WIDTH'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0] AF_C    = PTR_WIDTH'(AF_LEVEL);

    logic [PTR_WIDTH-1:0] wptr;
    logic [PTR_WIDTH-1:0] rptr;
    logic [PTR_WIDTH-1:0] cnt;
    logic                 push_ok;
    logic                 pop_ok;

    // Flags decode from the registered count only
    assign full        = (cnt == DEPTH_C);
    assign empty       = (cnt == '0);
    assign almost_full = (cnt >= AF_C);
    assign count       = cnt;

    // Flush blocks both sides so nothing reaches the RAM that cycle
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    assign ram_wr_en   = push_ok;
    assign ram_wr_addr = wptr;
    assign ram_wr_data = push_data;
    assign ram_rd_addr = rptr;

    fifo_wrap_ptr #(
        .DEPTH (FIFO_DEPTH),
        .W     (PTR_WIDTH)
    ) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (push_ok),
        .ptr   (wptr)
    );

    fifo_wrap_ptr #(
        .DEPTH (FIFO_DEPTH),
        .W     (PTR_WIDTH)
    ) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (pop_ok),
        .ptr   (rptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (flush) begin
                cnt <= '0;
            end else if (push_ok && !pop_ok) begin
                cnt <= cnt + PTR_WIDTH'(1);
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - PTR_WIDTH'(1);
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky; a new error in the err_clr cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl (depth 90, width 8).
// Includes a behavioural RAM so popped data can be checked in order.
module tb_sync_fifo_ctrl;

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic       flush;
    logic       err_clr;
    logic       ram_wr_en;
    logic [7:0] ram_wr_addr;
    logic [7:0] ram_wr_data;
    logic [7:0] ram_rd_addr;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [7:0] count;
    logic       overflow;
    logic       underflow;

    logic [7:0] mem [0:89];
    logic [7:0] rd_data;
    logic [7:0] q[$];
    logic [7:0] exp_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .flush       (flush),
        .err_clr     (err_clr),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_addr (ram_rd_addr),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Registered-read RAM model, both ports on clk
    always @(posedge clk) begin
        if (ram_wr_en && ram_wr_addr < 8'd90)
            mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_addr < 8'd90)
            rd_data <= mem[ram_rd_addr];
        else
            rd_data <= 8'hxx;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of push/pop with scoreboard-based expectations
    task automatic step(input bit p, input logic [7:0] d, input bit po);
        bit pok;
        bit pook;
        push      = p;
        push_data = d;
        pop       = po;
        pok  = p && (q.size() < 90);
        pook = po && (q.size() > 0);
        tick();
        if (pook) exp_rd = q.pop_front();
        if (pok) q.push_back(d);
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, pook});
        if (pook) chk("rd_data", {24'd0, rd_data}, {24'd0, exp_rd});
        chk("count", {24'd0, count}, q.size());
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; push = 0; pop = 0; flush = 0; err_clr = 0;
        push_data = 8'h00;
        #12;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {24'd0, count}, 32'd0);
        chk("rst_rdv", {31'd0, rd_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_empty", {31'd0, empty}, 32'd1);

        // Single word round trip
        step(1'b1, 8'hA5, 1'b0);
        chk("one_empty", {31'd0, empty}, 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("a5_data", {24'd0, rd_data}, 32'hA5);
        chk("a5_empty", {31'd0, empty}, 32'd1);

        // Simultaneous push/pop on empty: pop dropped
        step(1'b1, 8'h3C, 1'b1);
        chk("se_count", {24'd0, count}, 32'd1);
        step(1'b0, 8'h00, 1'b1);

        // Underflow attempt
        step(1'b0, 8'h00, 1'b1);
        chk("underflow", {31'd0, underflow}, {31'd0, ERR});

        // Fill from an offset start (pointers at 2)
        for (int i = 0; i < 90; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 84) chk("af_85", {31'd0, almost_full}, 32'd0);
            if (i == 85) chk("af_86", {31'd0, almost_full}, 32'd1);
            if (i == 88) chk("full_89", {31'd0, full}, 32'd0);
            if (i == 89) chk("full_90", {31'd0, full}, 32'd1);
        end
        push = 1'b1; push_data = 8'hEE;
        #1;
        chk("full_wr_en", {31'd0, ram_wr_en}, 32'd0);
        step(1'b1, 8'hEE, 1'b0);
        chk("overflow", {31'd0, overflow}, {31'd0, ERR});
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", {31'd0, overflow}, 32'd0);

        // Push and pop while full: push dropped
        step(1'b1, 8'hDD, 1'b1);
        chk("sf_count", {24'd0, count}, 32'd89);

        // Flush with push and pop at count 50
        while (q.size() > 50) step(1'b0, 8'h00, 1'b1);
        flush = 1'b1; push = 1'b1; pop = 1'b1; push_data = 8'h77;
        #1;
        chk("fl_wr_en", {31'd0, ram_wr_en}, 32'd0);
        tick();
        flush = 1'b0; push = 1'b0; pop = 1'b0;
        q.delete();
        chk("fl_count", {24'd0, count}, 32'd0);
        chk("fl_empty", {31'd0, empty}, 32'd1);
        chk("fl_rdv", {31'd0, rd_valid}, 32'd0);
        chk("fl_rptr", {24'd0, ram_rd_addr}, 32'd0);

        // Wrap-around: 90 in, 45 out, 45 in, 90 out
        for (int i = 0; i < 90; i++) step(1'b1, 8'(i + 100), 1'b0);
        for (int i = 0; i < 45; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 45; i++) step(1'b1, 8'(i), 1'b0);
        chk("wrap_wptr", {24'd0, ram_wr_addr}, 32'd45);
        for (int i = 0; i < 90; i++) begin
            if (i == 44) chk("rd_addr_89", {24'd0, ram_rd_addr}, 32'd89);
            if (i == 45) chk("rd_addr_0", {24'd0, ram_rd_addr}, 32'd0);
            step(1'b0, 8'h00, 1'b1);
        end

        // Steady push+pop at count 10
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i + 200), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i + 30), 1'b1);
        chk("ss_count", {24'd0, count}, 32'd10);

        // Async reset while rd_valid is high
        step(1'b0, 8'h00, 1'b1);
        chk("pre_rst_rdv", {31'd0, rd_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rdv", {31'd0, rd_valid}, 32'd0);
        chk("ar_count", {24'd0, count}, 32'd0);
        chk("ar_empty", {31'd0, empty}, 32'd1);
        chk("ar_afull", {31'd0, almost_full}, 32'd0);
        chk("ar_wr_en", {31'd0, ram_wr_en}, 32'd0);
        chk("ar_rd_addr", {24'd0, ram_rd_addr}, 32'd0);
        chk("ar_ovf", {31'd0, overflow}, 32'd0);
        chk("ar_unf", {31'd0, underflow}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
